// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches one- or two-byte instructions from a registered-read
// instruction memory and issues each decoded opcode to the control unit once,
// then advances or redirects the program counter.
module instr_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_data,
    output logic [4:0]        opIn,
    output logic [2:0]        reg_field,
    output logic [7:0]        imm,
    output logic              issue,
    input  logic              stall,
    input  logic              pcLine,
    input  logic              zero,
    input  logic              neg,
    output logic [ADDR_W-1:0] pc
);

    // Shared project opcode encodings (instruction byte bits [7:4])
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_SUB     = 4'h2;
    localparam logic [3:0] OP_AND     = 4'h3;
    localparam logic [3:0] OP_OR      = 4'h4;
    localparam logic [3:0] OP_XOR     = 4'h5;
    localparam logic [3:0] OP_LOADIMM = 4'h6;
    localparam logic [3:0] OP_LOAD    = 4'h7;
    localparam logic [3:0] OP_STORE   = 4'h8;
    localparam logic [3:0] OP_BR      = 4'h9;
    localparam logic [3:0] OP_BR_Z    = 4'hA;
    localparam logic [3:0] OP_BR_N    = 4'hB;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        LATCH     = 3'd1,
        FETCH_IMM = 3'd2,
        LATCH_IMM = 3'd3,
        ISSUE     = 3'd4
    } seqState_t;

    seqState_t   state;
    seqState_t   nextState;
    logic [7:0]  ir;
    logic [7:0]  fetchByte;
    logic [3:0]  irOp;
    logic        branchTaken;
    logic        latchIr;
    logic        latchImm;
    logic        advancePc;
    logic        loadPc;

    // Opcodes that carry a second (immediate / branch-target) byte
    function automatic logic isTwoByte(input logic [3:0] op);
        return (op == OP_LOADIMM) || (op == OP_BR) || (op == OP_BR_Z) || (op == OP_BR_N);
    endfunction

    assign fetchByte = 8'(imem_data);
    assign irOp      = ir[7:4];
    assign imem_addr = pc;
    assign reg_field = ir[2:0];

    // Branch condition; only consumed in the accepting issue cycle
    assign branchTaken = pcLine && ((irOp == OP_BR)
                                 || ((irOp == OP_BR_Z) && zero)
                                 || ((irOp == OP_BR_N) && neg));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            FETCH:     nextState = LATCH;
            LATCH:     nextState = isTwoByte(fetchByte[7:4]) ? FETCH_IMM : ISSUE;
            FETCH_IMM: nextState = LATCH_IMM;
            LATCH_IMM: nextState = ISSUE;
            ISSUE:     nextState = stall ? ISSUE : FETCH;
            default:   nextState = FETCH;
        endcase
    end

    // Moore outputs and datapath strobes; everything idles while rst is high
    always_comb begin
        imem_rd   = 1'b0;
        issue     = 1'b0;
        opIn      = 5'b00000;
        latchIr   = 1'b0;
        latchImm  = 1'b0;
        advancePc = 1'b0;
        loadPc    = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH:     imem_rd = 1'b1;
                LATCH: begin
                    latchIr   = 1'b1;
                    advancePc = 1'b1;
                end
                FETCH_IMM: imem_rd = 1'b1;
                LATCH_IMM: begin
                    latchImm  = 1'b1;
                    advancePc = 1'b1;
                end
                ISSUE: begin
                    issue  = 1'b1;
                    opIn   = ir[7:3];
                    loadPc = !stall && branchTaken;
                end
                default: begin
                    imem_rd = 1'b0;
                end
            endcase
        end
    end

    // Instruction, immediate and program-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ir  <= 8'h00;
            imm <= 8'h00;
            pc  <= '0;
        end else begin
            if (latchIr) begin
                ir <= fetchByte;
            end
            if (latchImm) begin
                imm <= fetchByte;
            end
            if (loadPc) begin
                pc <= ADDR_W'(imm);
            end else if (advancePc) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed program walk plus randomized
// instruction stream, checked through fetch and issue scoreboards.
module tb_instr_sequencer;

    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_LOADIMM = 4'h6;
    localparam logic [3:0] OP_BR      = 4'h9;
    localparam logic [3:0] OP_BR_Z    = 4'hA;
    localparam logic [3:0] OP_BR_N    = 4'hB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       pcLine = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic [7:0] imemAddr;
    logic       imemRd;
    logic [7:0] imemData = 8'h00;
    logic [4:0] opIn;
    logic [2:0] regField;
    logic [7:0] imm;
    logic       issue;
    logic [7:0] pc;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imemAddr),
        .imem_rd   (imemRd),
        .imem_data (imemData),
        .opIn      (opIn),
        .reg_field (regField),
        .imm       (imm),
        .issue     (issue),
        .stall     (stall),
        .pcLine    (pcLine),
        .zero      (zero),
        .neg       (neg),
        .pc        (pc)
    );

    // Registered-read instruction memory
    logic [7:0] mem [256];
    always @(posedge clk) if (imemRd) imemData <= mem[imemAddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] addr; int cyc; } fetchRec_t;
    typedef struct { logic [4:0] op; logic [2:0] rf; logic [7:0] imm; int firstCyc; int acceptCyc; } issueRec_t;

    fetchRec_t fetchQ[$];
    issueRec_t issueQ[$];
    int  total = 0;
    int  bad = 0;
    bit  done = 1'b0;
    logic [7:0] modelPc = 8'h00;
    logic [7:0] modelImm = 8'h00;

    function automatic bit isTwo(input logic [3:0] op);
        return (op == OP_LOADIMM) || (op == OP_BR) || (op == OP_BR_Z) || (op == OP_BR_N);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Execute the instruction at modelPc: k stall cycles, flags applied at acceptance
    task automatic runInstr(input int k, input bit pl, input bit z, input bit n);
        int         s;
        int         lat;
        logic [7:0] b;
        logic [7:0] a1;
        logic [7:0] immNew;
        logic [7:0] nextPc;
        bit         two;
        bit         taken;
        s      = cyc;
        b      = mem[modelPc];
        two    = isTwo(b[7:4]);
        a1     = modelPc + 8'd1;
        lat    = two ? 4 : 2;
        immNew = two ? mem[a1] : modelImm;
        fetchQ.push_back('{modelPc, s});
        if (two) fetchQ.push_back('{a1, s + 2});
        issueQ.push_back('{b[7:3], b[2:0], immNew, s + lat, s + lat + k});
        nextPc = modelPc + (two ? 8'd2 : 8'd1);
        taken  = pl && ((b[7:4] == OP_BR) || ((b[7:4] == OP_BR_Z) && z) || ((b[7:4] == OP_BR_N) && n));
        if (taken) nextPc = immNew;
        for (int i = 0; i < lat; i++) begin
            stall  = 1'($urandom_range(0, 1));
            pcLine = 1'($urandom_range(0, 1));
            zero   = 1'($urandom_range(0, 1));
            neg    = 1'($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < k; i++) begin
            stall  = 1'b1;
            pcLine = 1'b1;
            zero   = !z;
            neg    = !n;
            step();
        end
        stall  = 1'b0;
        pcLine = pl;
        zero   = z;
        neg    = n;
        step();
        modelPc  = nextPc;
        modelImm = immNew;
    endtask

    // Start a two-byte instruction and pulse rst during its immediate-latch cycle
    task automatic resetDuringLatchImm;
        int s;
        s = cyc;
        fetchQ.push_back('{modelPc, s});
        fetchQ.push_back('{modelPc + 8'd1, s + 2});
        for (int i = 0; i < 3; i++) begin
            stall = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        step();
        rst      = 1'b0;
        modelPc  = 8'h00;
        modelImm = 8'h00;
    endtask

    // Stimulus
    initial begin
        logic [7:0] vb [6] = '{8'h90, 8'hA0, 8'hA0, 8'hB8, 8'hA5, 8'h92};
        bit         vpl [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit         vz  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit         vn  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int         vk  [6] = '{0, 0, 0, 0, 3, 2};
        for (int i = 0; i < 256; i++) mem[i] = {OP_ADD, 4'h0};
        mem[8'h00] = 8'h13;
        mem[8'h01] = 8'h90; mem[8'h02] = 8'h04;
        mem[8'h04] = 8'h60; mem[8'h05] = 8'h5A;
        mem[8'h06] = 8'h90; mem[8'h07] = 8'h10;
        mem[8'h11] = 8'h40;
        mem[8'h12] = 8'h90; mem[8'h13] = 8'h10;
        mem[8'h40] = 8'h90; mem[8'h41] = 8'h10;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        runInstr(0, 1'b0, 1'b0, 1'b0);
        runInstr(0, 1'b1, 1'b0, 1'b0);
        runInstr(0, 1'b0, 1'b1, 1'b1);
        runInstr(0, 1'b1, 1'b0, 1'b0);
        for (int v = 0; v < 6; v++) begin
            mem[8'h10] = vb[v];
            runInstr(vk[v], vpl[v], vz[v], vn[v]);
            runInstr(0, 1'b1, 1'b0, 1'b0);
        end
        mem[8'h10] = 8'h90; mem[8'h11] = 8'hFF;
        runInstr(0, 1'b1, 1'b0, 1'b0);
        mem[8'hFF] = 8'h15;
        runInstr(0, 1'b0, 1'b0, 1'b0);
        runInstr(0, 1'b0, 1'b0, 1'b0);
        mem[8'h01] = 8'h90; mem[8'h02] = 8'hFE;
        runInstr(0, 1'b1, 1'b0, 1'b0);
        mem[8'hFE] = 8'hA1;
        runInstr(0, 1'b1, 1'b0, 1'b0);
        runInstr(0, 1'b0, 1'b0, 1'b0);
        resetDuringLatchImm();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 300; i++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            runInstr(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b1;
        repeat (2) step();
        done = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT fetches and issues against the scoreboards
    initial begin
        bit        prevRst;
        fetchRec_t f;
        issueRec_t e;
        prevRst = 1'b1;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rst) begin
                    check("rst_issue", 32'(issue), 32'd0);
                    check("rst_imem_rd", 32'(imemRd), 32'd0);
                    check("rst_opIn", 32'(opIn), 32'd0);
                end else begin
                    if (prevRst) begin
                        check("post_rst_pc", 32'(pc), 32'd0);
                        check("post_rst_imm", 32'(imm), 32'd0);
                        check("post_rst_reg_field", 32'(regField), 32'd0);
                    end
                    while (fetchQ.size() > 0 && fetchQ[0].cyc < cyc) begin
                        check("missed_fetch_cycle", 32'(cyc), 32'(fetchQ[0].cyc));
                        void'(fetchQ.pop_front());
                    end
                    if (imemRd) begin
                        if (fetchQ.size() == 0) begin
                            check("unexpected_fetch_addr", 32'(imemAddr), 32'hFFFF_FFFF);
                        end else begin
                            f = fetchQ.pop_front();
                            check("fetch_addr", 32'(imemAddr), 32'(f.addr));
                            check("fetch_cycle", 32'(cyc), 32'(f.cyc));
                            check("pc_at_fetch", 32'(pc), 32'(f.addr));
                        end
                    end
                    while (issueQ.size() > 0 && issueQ[0].acceptCyc < cyc) begin
                        check("missed_issue_cycle", 32'(cyc), 32'(issueQ[0].acceptCyc));
                        void'(issueQ.pop_front());
                    end
                    if (issue) begin
                        if (issueQ.size() == 0) begin
                            check("unexpected_issue_opIn", 32'(opIn), 32'hFFFF_FFFF);
                        end else begin
                            e = issueQ[0];
                            check("issue_opIn", 32'(opIn), 32'(e.op));
                            check("issue_reg_field", 32'(regField), 32'(e.rf));
                            check("issue_imm", 32'(imm), 32'(e.imm));
                            if (!stall) begin
                                check("accept_cycle", 32'(cyc), 32'(e.acceptCyc));
                                void'(issueQ.pop_front());
                            end else begin
                                check("stall_window_start", 32'(cyc >= e.firstCyc), 32'd1);
                            end
                        end
                    end else begin
                        check("idle_opIn", 32'(opIn), 32'd0);
                    end
                end
            end
            prevRst = rst;
            if (done) break;
        end
        check("fetch_queue_drained", 32'(fetchQ.size()), 32'd0);
        check("issue_queue_drained", 32'(issueQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
